phase_avg: RTL and testbench

//  Downstream of the peak detector. Consumes the per-peak interpolated phase stream
//  (NPEAKS entries per FFT frame, sop/eop framed). Averages phaseA/phaseB per peak

---
 rtl/peak_pkg.sv | 18 +
 rtl/phase_acc.sv | 45 ++++
 rtl/phase_avg.sv | 190 +++++++++++++++++++
 tb/tb_phase_avg.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// Shared phase types for the peak-detector / phase-averaging chain.
// Phases are Q1.15 signed values that wrap modulo 2**16.
package peak_pkg;

    typedef logic signed [15:0] phase_t;

    typedef struct packed {
        phase_t a;
        phase_t b;
    } phase_pair_t;

    localparam int PHASE_W = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_acc.sv
// One wrap-safe averaging channel: holds a reference phase and a sum of
// wrapped differences against it; avg_out includes the phase on phase_in.
module phase_acc
    import peak_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   add,
    input  phase_t phase_in,
    output phase_t avg_out
);

    localparam int AW = PHASE_W + LOG2N;

    phase_t                 ref_r;
    logic signed [AW-1:0]   acc_r;
    phase_t                 diff_s;
    logic signed [AW-1:0]   acc_sum_s;
    logic signed [AW-1:0]   acc_shift_s;

    // Wrapped difference and the running average including the current entry
    always_comb begin
        diff_s      = phase_in - ref_r;
        acc_sum_s   = acc_r + {{LOG2N{diff_s[PHASE_W-1]}}, diff_s};
        acc_shift_s = acc_sum_s >>> LOG2N;
        avg_out     = ref_r + phase_t'(acc_shift_s[PHASE_W-1:0]);
    end

    // Reference / accumulator state
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_r <= '0;
            acc_r <= '0;
        end else if (load) begin
            ref_r <= phase_in;
            acc_r <= '0;
        end else if (add) begin
            acc_r <= acc_sum_s;
        end
    end

endmodule

// File: rtl/phase_avg.sv
// Averages per-peak phaseA/phaseB over 2**LOG2N well-formed frames and
// streams one averaged NPEAKS-entry frame per block; malformed frames pulse frame_err.
module phase_avg
    import peak_pkg::*;
#(
    parameter int NPEAKS = 4,
    parameter int LOG2N  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    input  logic [15:0] sink_phaseA,
    input  logic [15:0] sink_phaseB,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    output logic [15:0] source_phaseA,
    output logic [15:0] source_phaseB,
    output logic        frame_err
);

    localparam int          IW       = idx_width(NPEAKS);
    localparam logic [IW:0] LAST_IDX = (IW+1)'(NPEAKS - 1);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} out_state_t;

    logic [IW-1:0]    idx_r;
    logic             in_frame_r;
    logic             bad_r;
    logic [LOG2N-1:0] k_r;
    phase_pair_t      stg_r    [NPEAKS];
    phase_pair_t      outbuf_r [NPEAKS];
    phase_t           commit_a_s [NPEAKS];
    phase_t           commit_b_s [NPEAKS];
    phase_t           avg_a_s    [NPEAKS];
    phase_t           avg_b_s    [NPEAKS];

    logic             accept_s, overflow_s, bad_now_s, good_eop_s, err_s;
    logic             load_s, add_s, final_s;
    logic [IW:0]      land_idx_s;

    // Frame-shape check: where this entry lands and whether its eop commits
    always_comb begin
        accept_s = sink_valid && (sink_sop || in_frame_r);
        if (sink_sop) begin
            land_idx_s = '0;
            overflow_s = 1'b0;
        end else begin
            land_idx_s = {1'b0, idx_r} + (IW+1)'(1);
            overflow_s = ({1'b0, idx_r} == LAST_IDX);
        end
        bad_now_s  = !sink_sop && (bad_r || overflow_s);
        good_eop_s = accept_s && sink_eop && !bad_now_s && (land_idx_s == LAST_IDX);
        err_s      = accept_s && sink_eop && !good_eop_s;
        load_s     = good_eop_s && (k_r == '0);
        add_s      = good_eop_s && (k_r != '0);
        final_s    = good_eop_s && (k_r == '1);
    end

    // Frame tracking, block counter and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r      <= '0;
            in_frame_r <= 1'b0;
            bad_r      <= 1'b0;
            k_r        <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= err_s;
            if (accept_s) begin
                in_frame_r <= !sink_eop;
                bad_r      <= bad_now_s;
                if (!bad_now_s) begin
                    idx_r <= land_idx_s[IW-1:0];
                end
            end
            if (good_eop_s) begin
                k_r <= k_r + LOG2N'(1);
            end
        end
    end

    // Staging of the frame in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NPEAKS; p++) begin
                stg_r[p] <= '0;
            end
        end else if (accept_s && !bad_now_s) begin
            for (int p = 0; p < NPEAKS; p++) begin
                if (land_idx_s == (IW+1)'(p)) begin
                    stg_r[p] <= {phase_t'(sink_phaseA), phase_t'(sink_phaseB)};
                end
            end
        end
    end

    // The last peak of a committing frame is still on the sink bus
    for (genvar p = 0; p < NPEAKS; p++) begin : g_chan
        if (p == NPEAKS - 1) begin : g_bus
            assign commit_a_s[p] = phase_t'(sink_phaseA);
            assign commit_b_s[p] = phase_t'(sink_phaseB);
        end else begin : g_stg
            assign commit_a_s[p] = stg_r[p].a;
            assign commit_b_s[p] = stg_r[p].b;
        end

        phase_acc #(.LOG2N(LOG2N)) u_acc_a (
            .clk(clk), .reset(reset), .load(load_s), .add(add_s),
            .phase_in(commit_a_s[p]), .avg_out(avg_a_s[p])
        );
        phase_acc #(.LOG2N(LOG2N)) u_acc_b (
            .clk(clk), .reset(reset), .load(load_s), .add(add_s),
            .phase_in(commit_b_s[p]), .avg_out(avg_b_s[p])
        );
    end

    out_state_t    state_r, state_nx_s;
    logic [IW-1:0] out_idx_r, out_idx_nx_s;
    logic          valid_nx_s, sop_nx_s, eop_nx_s;
    phase_t        a_nx_s, b_nx_s;

    // Output FSM next state; entry 0 leaves straight from the averaging bus
    always_comb begin
        state_nx_s   = IDLE;
        out_idx_nx_s = '0;
        valid_nx_s   = 1'b0;
        sop_nx_s     = 1'b0;
        eop_nx_s     = 1'b0;
        a_nx_s       = '0;
        b_nx_s       = '0;
        if (final_s) begin
            state_nx_s = STREAM;
            valid_nx_s = 1'b1;
            sop_nx_s   = 1'b1;
            eop_nx_s   = (NPEAKS == 1);
            a_nx_s     = avg_a_s[0];
            b_nx_s     = avg_b_s[0];
        end else begin
            case (state_r)
                STREAM: begin
                    if (out_idx_r != IW'(NPEAKS - 1)) begin
                        state_nx_s   = STREAM;
                        out_idx_nx_s = out_idx_r + IW'(1);
                        valid_nx_s   = 1'b1;
                        eop_nx_s     = (out_idx_nx_s == IW'(NPEAKS - 1));
                        a_nx_s       = outbuf_r[out_idx_nx_s].a;
                        b_nx_s       = outbuf_r[out_idx_nx_s].b;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                IDLE:    state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // Output registers, FSM state and the averaged frame buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            out_idx_r     <= '0;
            source_valid  <= 1'b0;
            source_sop    <= 1'b0;
            source_eop    <= 1'b0;
            source_phaseA <= '0;
            source_phaseB <= '0;
            for (int p = 0; p < NPEAKS; p++) begin
                outbuf_r[p] <= '0;
            end
        end else begin
            state_r       <= state_nx_s;
            out_idx_r     <= out_idx_nx_s;
            source_valid  <= valid_nx_s;
            source_sop    <= sop_nx_s;
            source_eop    <= eop_nx_s;
            source_phaseA <= a_nx_s;
            source_phaseB <= b_nx_s;
            if (final_s) begin
                for (int p = 0; p < NPEAKS; p++) begin
                    outbuf_r[p] <= {avg_a_s[p], avg_b_s[p]};
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_avg.sv
// Directed bench for phase_avg (NPEAKS=4, LOG2N=2): a block-averaging model
// predicts every output cycle, plus literal checks on hand-computed results.
module tb_phase_avg;

    localparam int NPEAKS = 4;
    localparam int LOG2N  = 2;
    localparam int NF     = 1 << LOG2N;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
    logic [15:0] sink_phaseA = '0, sink_phaseB = '0;
    logic        source_valid, source_sop, source_eop, frame_err;
    logic [15:0] source_phaseA, source_phaseB;

    phase_avg #(.NPEAKS(NPEAKS), .LOG2N(LOG2N)) dut (
        .clk(clk), .reset(reset),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_phaseA(sink_phaseA), .sink_phaseB(sink_phaseB),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_phaseA(source_phaseA), .source_phaseB(source_phaseB),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        sop;
        logic        eop;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        exp_q[$];
    int          err_q[$];
    int          tests = 0, fails = 0;
    bit          chk_en = 1'b0;
    logic [15:0] fa [8];
    logic [15:0] fb [8];
    logic [15:0] blk_a [NF][NPEAKS];
    logic [15:0] blk_b [NF][NPEAKS];
    int          nblk = 0;
    int          last_eop_cyc = 0, sop_cyc = 0, out_frames = 0, err_seen = 0, pos = 0;
    logic [15:0] out_a [NPEAKS];
    logic [15:0] out_b [NPEAKS];

    // Block average: ref = first frame, plus floor of the mean wrapped difference
    function automatic logic [15:0] avg_col(input logic [15:0] col [NF]);
        int          s = 0;
        logic [15:0] d;
        for (int f = 1; f < NF; f++) begin
            d = col[f] - col[0];
            s += int'($signed(d));
        end
        return col[0] + 16'(s >>> LOG2N);
    endfunction

    task automatic model_good_frame(input int eop_cyc);
        logic [15:0] ca [NF];
        logic [15:0] cb [NF];
        exp_t        e;
        for (int p = 0; p < NPEAKS; p++) begin
            blk_a[nblk][p] = fa[p];
            blk_b[nblk][p] = fb[p];
        end
        nblk++;
        if (nblk == NF) begin
            for (int p = 0; p < NPEAKS; p++) begin
                for (int f = 0; f < NF; f++) begin
                    ca[f] = blk_a[f][p];
                    cb[f] = blk_b[f][p];
                end
                e.cyc = eop_cyc + 1 + p;
                e.sop = (p == 0);
                e.eop = (p == NPEAKS - 1);
                e.a   = avg_col(ca);
                e.b   = avg_col(cb);
                exp_q.push_back(e);
            end
            nblk = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // n entries framed by sop/eop; only n==NPEAKS is a good frame
    task automatic send_frame(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            sink_valid  = 1'b1;
            sink_sop    = (i == 0);
            sink_eop    = (i == n - 1);
            sink_phaseA = fa[i];
            sink_phaseB = fb[i];
            if (i == n - 1) c = cyc;
            tick();
        end
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        last_eop_cyc = c;
        if (n == NPEAKS) model_good_frame(c);
        else err_q.push_back(c + 1);
    endtask

    task automatic set4(input logic [15:0] a0, a1, a2, a3);
        fa[0] = a0; fa[1] = a1; fa[2] = a2; fa[3] = a3;
        fa[4] = 16'h5555; fa[5] = 16'h6666;
        for (int i = 0; i < 8; i++) fb[i] = 16'h0000 - fa[i];
    endtask

    task automatic drain();
        repeat (8) tick();
    endtask

    task automatic do_reset();
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].cyc > cyc) exp_q.delete(i);
        for (int i = err_q.size() - 1; i >= 0; i--) if (err_q[i] > cyc) err_q.delete(i);
        nblk  = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            logic exp_err;
            e = '{cyc: cyc, sop: 1'b0, eop: 1'b0, a: 16'h0000, b: 16'h0000};
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                tests++;
                if (source_valid !== 1'b1 || source_sop !== e.sop || source_eop !== e.eop ||
                    source_phaseA !== e.a || source_phaseB !== e.b) begin
                    fails++;
                    $display("FAIL stream@%0d: got v=%b s=%b e=%b A=%h B=%h, expected v=1 s=%b e=%b A=%h B=%h",
                             cyc, source_valid, source_sop, source_eop, source_phaseA, source_phaseB,
                             e.sop, e.eop, e.a, e.b);
                end
            end else begin
                tests++;
                if ({source_valid, source_sop, source_eop, source_phaseA, source_phaseB} !== 35'd0) begin
                    fails++;
                    $display("FAIL idle@%0d: got v=%b s=%b e=%b A=%h B=%h, expected all 0",
                             cyc, source_valid, source_sop, source_eop, source_phaseA, source_phaseB);
                end
            end
            exp_err = (err_q.size() > 0 && err_q[0] == cyc);
            if (exp_err) void'(err_q.pop_front());
            tests++;
            if (frame_err !== exp_err) begin
                fails++;
                $display("FAIL frame_err@%0d: got %b, expected %b", cyc, frame_err, exp_err);
            end
            if (frame_err === 1'b1) err_seen++;
            if (source_valid === 1'b1) begin
                if (source_sop === 1'b1) begin
                    pos = 0;
                    sop_cyc = cyc;
                end
                if (pos < NPEAKS) begin
                    out_a[pos] = source_phaseA;
                    out_b[pos] = source_phaseB;
                end
                pos++;
                if (source_eop === 1'b1) out_frames++;
            end
        end
    end

    initial begin
        int f0, e0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_valid", {31'd0, source_valid}, 32'd0);
        check("reset_phaseA", {16'd0, source_phaseA}, 32'd0);
        chk_en = 1'b1;
        tick();

        // Constant frames: output equals input
        set4(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        repeat (4) send_frame(4);
        drain();
        check("const_a0", {16'd0, out_a[0]}, 32'h1000);
        check("const_a3", {16'd0, out_a[3]}, 32'h4000);
        check("const_b1", {16'd0, out_b[1]}, 32'hE000);
        check("const_latency", sop_cyc - last_eop_cyc, 32'd1);

        // Wrap across +/-1
        for (int f = 0; f < 4; f++) begin
            set4((f % 2 == 0) ? 16'h7F00 : 16'h8100, 16'h0100, 16'h0200, 16'h0300);
            send_frame(4);
        end
        drain();
        check("wrap_a0", {16'd0, out_a[0]}, 32'h8000);
        check("wrap_b0", {16'd0, out_b[0]}, 32'h8000);

        // Floor toward minus infinity
        for (int f = 0; f < 4; f++) begin
            set4((f == 0) ? 16'h0000 : 16'h0001, 16'h0000, 16'h0000, 16'h0000);
            send_frame(4);
        end
        drain();
        check("floor_pos", {16'd0, out_a[0]}, 32'h0000);
        check("floor_pos_b", {16'd0, out_b[0]}, 32'hFFFF);
        for (int f = 0; f < 4; f++) begin
            set4((f == 0) ? 16'h0000 : 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
            send_frame(4);
        end
        drain();
        check("floor_neg", {16'd0, out_a[0]}, 32'hFFFF);

        // Malformed short frame is dropped
        f0 = out_frames;
        e0 = err_seen;
        set4(16'h7000, 16'h7000, 16'h7000, 16'h7000);
        send_frame(3);
        drain();
        check("short_no_output", out_frames - f0, 32'd0);
        check("short_err", err_seen - e0, 32'd1);
        for (int f = 0; f < 4; f++) begin
            set4(16'((f + 1) * 256), 16'h0400, 16'h0500, 16'h0600);
            send_frame(4);
        end
        drain();
        check("after_short_a0", {16'd0, out_a[0]}, 32'h0280);

        // Back-to-back blocks, then an overrun
        f0 = out_frames;
        set4(16'h1111, 16'h0001, 16'h0002, 16'h0003);
        repeat (4) send_frame(4);
        set4(16'h2222, 16'h0011, 16'h0012, 16'h0013);
        repeat (4) send_frame(4);
        drain();
        check("b2b_frames", out_frames - f0, 32'd2);
        check("b2b_second_a0", {16'd0, out_a[0]}, 32'h2222);
        e0 = err_seen;
        send_frame(6);
        drain();
        check("overrun_err", err_seen - e0, 32'd1);

        // Reset while streaming entry 1
        set4(16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00);
        repeat (4) send_frame(4);
        tick();
        check("pre_reset_entry1", {16'd0, source_phaseA}, 32'h0B00);
        do_reset();
        check("post_reset_valid", {31'd0, source_valid}, 32'd0);
        for (int f = 0; f < 4; f++) begin
            set4(16'h3000 + 16'(f * 16), 16'h0010, 16'h0020, 16'h0030);
            send_frame(4);
        end
        drain();
        check("post_reset_a0", {16'd0, out_a[0]}, 32'h3018);
        check("post_reset_a3", {16'd0, out_a[3]}, 32'h0030);
        check("queues_empty", exp_q.size() + err_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
